// File: rtl/tri_counter_feed.sv
// tri_counter_feed: three-channel run-gated event counter with atomic valid/ready snapshot output.
// Build option: define SNAP_CLEAR_EN for read-and-clear counters on each capture.
module tri_counter_feed #(
  parameter int WIDTH = 8,
  parameter bit RUN_ON_RESET = 1'b0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             stop,
  input  logic             clear,
  input  logic             inc_a,
  input  logic             inc_b,
  input  logic             inc_c,
  input  logic             snap_req,
  input  logic             out_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] a,
  output logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] c,
  output logic [2:0]       ovf,
  output logic             snap_drop,
  output logic             running
);
  typedef enum logic {IDLE, RUN} state_t;
`ifdef SNAP_CLEAR_EN
  localparam bit SNAP_CLR = 1'b1;
`else
  localparam bit SNAP_CLR = 1'b0;
`endif
  state_t state, state_n;
  logic [WIDTH-1:0] cnt [3];
  logic [2:0] hit;
  logic take;
  always_ff @(posedge clk or posedge reset)
    if (reset) state <= RUN_ON_RESET ? RUN : IDLE;
    else state <= state_n;
  always_comb begin
    state_n = stop ? IDLE : (start ? RUN : state);
    hit = {inc_c, inc_b, inc_a} & {3{state == RUN}};
    take = snap_req && (!out_valid || out_ready);
  end
  assign running = (state == RUN);
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      cnt <= '{default: '0};
      ovf <= '0;
    end else begin
      for (int i = 0; i < 3; i++)
        if (clear) begin
          cnt[i] <= '0;
          ovf[i] <= 1'b0;
        end else if (SNAP_CLR && take) begin
          cnt[i] <= WIDTH'(hit[i]);
          ovf[i] <= 1'b0;
        end else begin
          cnt[i] <= cnt[i] + WIDTH'(hit[i]);
          if (hit[i] && &cnt[i]) ovf[i] <= 1'b1;
        end
    end
  // Capture takes pre-increment, pre-clear counts; accept and capture together keep the slot full.
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      out_valid <= 1'b0;
      a <= '0;
      b <= '0;
      c <= '0;
      snap_drop <= 1'b0;
    end else begin
      snap_drop <= snap_req && !take;
      if (take) begin
        out_valid <= 1'b1;
        a <= cnt[0];
        b <= cnt[1];
        c <= cnt[2];
      end else if (out_ready) out_valid <= 1'b0;
    end
endmodule

// File: doc/tri_counter_feed.md
Name: tri_counter_feed

Overview:
- Three-channel event counter. Produces the three operand buses a, b, c consumed by the downstream 8-bit OR-combine stage in the counter datapath.
- Each channel counts strobe events while the block is running.
- A snapshot request latches all three counts atomically into an output register. The register is presented with a valid/ready handshake, so the OR stage always sees one coherent triple.

Parameters:
- WIDTH, 8, width of each counter and of each output bus
- RUN_ON_RESET, 0, 1 = FSM leaves reset in RUN; 0 = leaves reset in IDLE

Ports:
- clk  input  1  system clock, rising edge
- reset  input  1  asynchronous, active-high reset
- start  input  1  pulse; IDLE -> RUN
- stop  input  1  pulse; RUN -> IDLE
- clear  input  1  synchronous clear of all three counters and overflow flags
- inc_a  input  1  event strobe, channel A (+1)
- inc_b  input  1  event strobe, channel B (+1)
- inc_c  input  1  event strobe, channel C (+1)
- snap_req  input  1  pulse; request snapshot of current counts
- out_ready  input  1  downstream accepts the snapshot
- out_valid  output  1  snapshot register holds unconsumed data
- a  output  WIDTH  snapshot of channel A count
- b  output  WIDTH  snapshot of channel B count
- c  output  WIDTH  snapshot of channel C count
- ovf  output  3  sticky per-channel wrap flags {C,B,A}
- snap_drop  output  1  one-cycle pulse: snap_req was refused
- running  output  1  FSM is in RUN

Behaviour:
- Reset (async, immediate, mid-operation included):
  - cnt_a/b/c = 0, a/b/c = 0, out_valid = 0, ovf = 0, snap_drop = 0.
  - FSM = RUN if RUN_ON_RESET else IDLE; running reflects this.
- FSM, two states:
  - IDLE: start -> RUN.
  - RUN: stop -> IDLE.
  - start and stop together: stop wins, FSM goes to or stays in IDLE.
  - running = (state == RUN), registered.
- Counting (RUN only):
  - Channel x increments by 1 on the cycle inc_x is sampled high.
  - Strobes in IDLE are ignored.
  - Arithmetic is modulo 2^WIDTH: 2^WIDTH-1 plus 1 gives 0 and sets ovf[x], which stays set until clear or reset.
- clear:
  - Highest priority after reset.
  - Zeroes counters and ovf at the next edge, in any state.
  - A strobe in the same cycle is lost; the counter reads 0.
  - Does not affect the FSM, out_valid or a/b/c.
- Snapshot capture:
  - snap_req is honoured in either state when the output slot is free: out_valid = 0, or out_valid = 1 and out_ready = 1 in that same cycle.
  - The captured value is the pre-increment counter value of that cycle. An event in the same cycle counts toward the next snapshot.
  - snap_req together with clear: snapshot takes the pre-clear values.
- Output handshake:
  - Capture sets out_valid = 1 at the next edge.
  - While out_valid = 1 and out_ready = 0, a/b/c and out_valid stay stable.
  - out_valid = 1 and out_ready = 1 with no new capture clears out_valid at the next edge.
  - A simultaneous accept and capture keeps out_valid = 1 and loads the new values: back-to-back, zero bubble.
  - out_ready while out_valid = 0 has no effect.
- Drop:
  - snap_req while the slot is occupied and not being accepted causes no capture.
  - snap_drop pulses high for exactly the next cycle.
- Latency:
  - Strobe to counter: 1 cycle.
  - snap_req to out_valid/a/b/c: 1 cycle.
  - All outputs are registered; there is no combinational path from inputs to outputs.

Optional Feature:
- Macro SNAP_CLEAR_EN.
- Defined: read-and-clear.
  - On a successful capture, each counter loads 0, or loads 1 if its strobe is active in that cycle and the FSM is in RUN.
  - ovf is cleared on the same edge.
- Undefined: counters are free-running; capture does not disturb counters or ovf.

Test Plan:
- Reset mid-run: drive 5 inc_a in RUN, assert reset asynchronously between edges -> a/b/c/ovf/out_valid drop to 0 immediately; running = RUN_ON_RESET.
- Basic count and snap: start; 3 inc_a, 7 inc_b, 0 inc_c; snap_req with out_ready = 1 -> one cycle later out_valid = 1, a = 3, b = 7, c = 0; out_valid clears the following cycle.
- Wrap: WIDTH = 8, 256 inc_c in RUN, then snap -> c = 0, ovf = 3'b100; clear -> ovf = 0.
- Back-pressure and drop: out_ready = 0, snap at a = 2, then snap again at a = 4 -> a remains 2, snap_drop pulses once; raise out_ready with a simultaneous snap -> out_valid stays 1, a = 4 (SNAP_CLEAR_EN off).
- IDLE gating, start/stop collision: stop, then 10 inc_b -> b unchanged on next snap; start and stop in the same cycle -> running = 0.
- SNAP_CLEAR_EN defined: 4 inc_a, then snap with inc_a high in the same cycle -> a = 4; a second snap 1 cycle later -> a = 1.
